// File: rtl/priority_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : priority_arbiter_pkg
// Purpose  : Shared mode constants, FSM state encoding and width helper for
//            the priority arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package priority_arbiter_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width with a floor of one bit so a single channel still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : priority_arbiter_pkg
`default_nettype wire

// File: rtl/priority_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : priority_arbiter_if
// Purpose  : Request/grant bundle between requesters, the arbiter and the
//            shared consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface priority_arbiter_if
  import priority_arbiter_pkg::*;
#(
  parameter int CHANNELS = 8
);
  localparam int IDX_W = idx_width(CHANNELS);

  logic                enable;
  logic                mode;
  logic [CHANNELS-1:0] req;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic [CHANNELS-1:0] grant_onehot;
  logic                grant_ready;

  // Arbiter side
  modport slave (
    input  enable, mode, req, grant_ready,
    output grant_valid, grant_idx, grant_onehot
  );

  // Requester / consumer side
  modport master (
    output enable, mode, req, grant_ready,
    input  grant_valid, grant_idx, grant_onehot
  );

endinterface : priority_arbiter_if
`default_nettype wire

// File: rtl/priority_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : priority_pick
// Purpose  : Combinational winner search. Scans start-1, start-2, ... modulo
//            CHANNELS, ending at start; fixed mode forces start to zero so
//            the scan becomes highest-index-first.
// Revision : 1.0 - initial release
// ============================================================================
module priority_pick
  import priority_arbiter_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int IDX_W    = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    start,
  input  logic                mode,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  // First set request in descending circular order from the start pointer
  always_comb begin
    int               start_i;
    int               pos;
    logic [IDX_W-1:0] pos_c;
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_c   = '0;
    start_i = (mode == MODE_RR) ? int'(start) : 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      // Wrap by CHANNELS, not by 2**IDX_W, so odd channel counts never
      // produce an out-of-range index.
      pos = start_i - k;
      if (pos < 0) pos = pos + CHANNELS;
      pos_c = IDX_W'(pos);
      if (!found && req[pos_c]) begin
        found = 1'b1;
        idx   = pos_c;
      end
    end
  end

endmodule : priority_pick
`default_nettype wire

// File: rtl/priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : priority_arbiter
// Purpose  : Registered N-channel arbiter, fixed-priority or round-robin,
//            presenting one grant at a time with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int CHANNELS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  priority_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(CHANNELS);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_grant_valid;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [CHANNELS-1:0] r_grant_onehot;
  logic [IDX_W-1:0]    r_rr_ptr;

  logic                w_accept;
  logic                w_decide;
  logic [IDX_W-1:0]    w_ptr_eff;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick_idx;

  priority_pick #(
    .CHANNELS (CHANNELS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .start (w_ptr_eff),
    .mode  (bus.mode),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  // Handshake decode, decision qualification and next-state selection
  always_comb begin
    w_accept     = r_grant_valid & bus.grant_ready;
    // On an accept cycle the pointer is being loaded with the accepted index;
    // searching from that value keeps back-to-back round-robin rotating
    // without a one-grant lag.
    w_ptr_eff    = w_accept ? r_grant_idx : r_rr_ptr;
    w_decide     = bus.enable & w_found & ((r_state == IDLE) | w_accept);
    w_state_next = r_state;
    if (w_decide) begin
      w_state_next = GRANT;
    end else if (w_accept) begin
      w_state_next = IDLE;
    end
  end

  // State, pointer and grant output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_grant_valid  <= 1'b0;
      r_grant_idx    <= '0;
      r_grant_onehot <= '0;
      r_rr_ptr       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rr_ptr <= r_grant_idx;
      end
      if (w_decide) begin
        r_grant_valid  <= 1'b1;
        r_grant_idx    <= w_pick_idx;
        r_grant_onehot <= CHANNELS'(1) << w_pick_idx;
      end else if (w_accept) begin
        // Index is left at its last value; only valid and one-hot clear.
        r_grant_valid  <= 1'b0;
        r_grant_onehot <= '0;
      end
    end
  end

  assign bus.grant_valid  = r_grant_valid;
  assign bus.grant_idx    = r_grant_idx;
  assign bus.grant_onehot = r_grant_onehot;

endmodule : priority_arbiter
`default_nettype wire
